// File: rtl/count_seq_checker.sv
// Self-check for a free-running modulo-MOD counter: seeds, locks, flags slips.
// Optional macro TC_CHECK_EN adds the tc_in check to the correctness test.
module count_seq_checker #(
    parameter int CNT_W    = 2,
    parameter int MOD      = 3,
    parameter int TC_AT    = 2,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] count_in,
    input  logic             tc_in,
    input  logic             clr_err,
    output logic             locked,
    output logic [CNT_W-1:0] exp_count,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic             wrap_pulse
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] SEED    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(MOD - 1);
    localparam logic [CNT_W:0]   MOD_X  = (CNT_W + 1)'(MOD);
    localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(LOCK_CNT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             errp_q, errp_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] ecnt_q, ecnt_d;
    logic [ERR_W-1:0] wcnt_q, wcnt_d;
    logic             wrapp_q, wrapp_d;

    logic             in_range;
    logic             tc_ok;
    logic             ok;
    logic [CNT_W-1:0] nxt;

    assign in_range = ({1'b0, count_in} < MOD_X);
    assign nxt      = (count_in == LAST) ? '0 : count_in + 1'b1;

`ifdef TC_CHECK_EN
    assign tc_ok = (tc_in == (count_in == CNT_W'(TC_AT)));
`else
    assign tc_ok = tc_in | 1'b1;
`endif

    assign ok = in_range && (count_in == exp_q) && tc_ok;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        run_d    = run_q;
        errp_d   = 1'b0;
        wrapp_d  = 1'b0;
        sticky_d = clr_err ? 1'b0 : sticky_q;
        ecnt_d   = clr_err ? '0 : ecnt_q;
        wcnt_d   = wcnt_q;
        if (sample_en) begin
            unique case (state_q)
                SEED: begin
                    if (in_range) begin
                        exp_d   = nxt;
                        run_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (ok) begin
                        exp_d = nxt;
                        if (state_q == ACQUIRE) begin
                            run_d = run_q + 1'b1;
                            if (run_q == RUN_TOP) state_d = LOCKED;
                        end else if (count_in == LAST) begin
                            wrapp_d = 1'b1;
                            if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
                        end
                    end else begin
                        // A slip re-acquires from the observed value
                        run_d = '0;
                        if (in_range) begin
                            exp_d   = nxt;
                            state_d = ACQUIRE;
                        end else begin
                            state_d = SEED;
                        end
                        if (state_q == LOCKED) begin
                            errp_d   = 1'b1;
                            sticky_d = 1'b1;
                            if (ecnt_d != '1) ecnt_d = ecnt_d + 1'b1;
                        end
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            exp_q    <= '0;
            run_q    <= '0;
            errp_q   <= 1'b0;
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
            wcnt_q   <= '0;
            wrapp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            errp_q   <= errp_d;
            sticky_q <= sticky_d;
            ecnt_q   <= ecnt_d;
            wcnt_q   <= wcnt_d;
            wrapp_q  <= wrapp_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign exp_count  = exp_q;
    assign err_pulse  = errp_q;
    assign err_sticky = sticky_q;
    assign err_count  = ecnt_q;
    assign wrap_count = wcnt_q;
    assign wrap_pulse = wrapp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker; honours TC_CHECK_EN like the DUT.
module tb_count_seq_checker;

    localparam int CNT_W    = 2;
    localparam int MOD      = 3;
    localparam int TC_AT    = 2;
    localparam int LOCK_CNT = 2;
    localparam int ERR_W    = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_en = 1'b0;
    logic [CNT_W-1:0] count_in = '0;
    logic             tc_in = 1'b0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic [CNT_W-1:0] exp_count;
    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic [ERR_W-1:0] wrap_count;
    logic             wrap_pulse;

    count_seq_checker #(
        .CNT_W(CNT_W), .MOD(MOD), .TC_AT(TC_AT),
        .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .count_in(count_in), .tc_in(tc_in), .clr_err(clr_err),
        .locked(locked), .exp_count(exp_count),
        .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .wrap_count(wrap_count),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lk;
        logic [CNT_W-1:0] ex;
        logic             ep;
        logic             es;
        logic [ERR_W-1:0] ec;
        logic [ERR_W-1:0] wc;
        logic             wp;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: 0 seed, 1 acquire, 2 locked
    int mst, mexp, mrun, mec, mwc;
    bit ms, mep, mwp;

    task automatic reseed(input int c);
        mrun = 0;
        if (c < MOD) begin
            mexp = (c + 1) % MOD;
            mst  = 1;
        end else begin
            mst = 0;
        end
    endtask

    task automatic model(input bit en, input int c, input bit t,
                         input bit clr, input bit rst);
        bit ok, tcok;
        if (rst) begin
            mst = 0; mexp = 0; mrun = 0; mec = 0; mwc = 0;
            ms = 0; mep = 0; mwp = 0;
            return;
        end
        mep = 0;
        mwp = 0;
        if (clr) begin
            ms  = 0;
            mec = 0;
        end
        if (!en) return;
`ifdef TC_CHECK_EN
        tcok = (t == (c == TC_AT));
`else
        tcok = 1;
`endif
        ok = (c < MOD) && (c == mexp) && tcok;
        case (mst)
            0: if (c < MOD) begin
                mexp = (c + 1) % MOD;
                mrun = 0;
                mst  = 1;
            end
            1: if (ok) begin
                mexp = (c + 1) % MOD;
                mrun++;
                if (mrun == LOCK_CNT) mst = 2;
            end else reseed(c);
            default: if (ok) begin
                mexp = (c + 1) % MOD;
                if (c == MOD - 1) begin
                    mwp = 1;
                    if (mwc < 255) mwc++;
                end
            end else begin
                mep = 1;
                ms  = 1;
                if (mec < 255) mec++;
                reseed(c);
            end
        endcase
    endtask

    task automatic step(input bit en, input int c, input bit t,
                        input bit clr, input bit rst);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        sample_en = en;
        count_in  = CNT_W'(c);
        tc_in     = t;
        clr_err   = clr;
        model(en, c, t, clr, rst);
        e.lk = (mst == 2);
        e.ex = CNT_W'(mexp);
        e.ep = mep;
        e.es = ms;
        e.ec = ERR_W'(mec);
        e.wc = ERR_W'(mwc);
        e.wp = mwp;
        q.push_back(e);
    endtask

    task automatic feed_ok(input int n);
        repeat (n) step(1, mexp, (mexp == TC_AT), 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{locked, exp_count, err_pulse, err_sticky,
                  err_count, wrap_count, wrap_pulse};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got lk=%b ex=%0d ep=%b es=%b ec=%0d wc=%0d wp=%b want lk=%b ex=%0d ep=%b es=%b ec=%0d wc=%0d wp=%b",
                    $time, a.lk, a.ex, a.ep, a.es, a.ec, a.wc, a.wp,
                    e.lk, e.ex, e.ep, e.es, e.ec, e.wc, e.wp);
            end
        end
    end

    task automatic test_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        settle();
        vectors++;
        if ({locked, err_count, wrap_count} !== '0) begin
            miscompares++;
            $display("FAIL reset got lk=%b ec=%0d wc=%0d want 0",
                locked, err_count, wrap_count);
        end
    endtask

    task automatic test_lock();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        settle();
        vectors++;
        if (locked !== 1'b1 || wrap_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL lock3 got lk=%b wp=%b want 1 0", locked, wrap_pulse);
        end
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        settle();
        vectors++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap got wp=%b wc=%0d ec=%0d want 1 1 0",
                wrap_pulse, wrap_count, err_count);
        end
    endtask

    task automatic test_skip();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        settle();
        vectors++;
        if (err_pulse !== 1'b1 || err_sticky !== 1'b1 ||
            err_count !== 8'd1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL skip got ep=%b es=%b ec=%0d lk=%b want 1 1 1 0",
                err_pulse, err_sticky, err_count, locked);
        end
        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        settle();
        vectors++;
        if (locked !== 1'b1 || err_count !== 8'd1 || err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL relock got lk=%b ec=%0d ep=%b want 1 1 0",
                locked, err_count, err_pulse);
        end
    endtask

    task automatic test_tc();
        logic [ERR_W-1:0] ec0, wc0;
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        settle();
        ec0 = err_count;
        wc0 = wrap_count;
        step(1, 2, 0, 0, 0);
        settle();
        vectors++;
`ifdef TC_CHECK_EN
        if (err_count !== ec0 + 1'b1 || wrap_count !== wc0) begin
`else
        if (err_count !== ec0 || wrap_count !== wc0 + 1'b1) begin
`endif
            miscompares++;
            $display("FAIL tc_check got ec=%0d wc=%0d from ec=%0d wc=%0d",
                err_count, wrap_count, ec0, wc0);
        end
        feed_ok(3);
    endtask

    task automatic test_range();
        step(1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        settle();
        vectors++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || exp_count !== 2'd1) begin
            miscompares++;
            $display("FAIL range got lk=%b ep=%b ex=%0d want 0 0 1",
                locked, err_pulse, exp_count);
        end
        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        settle();
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL range_relock got lk=%b want 1", locked);
        end
    endtask

    task automatic test_saturate();
        int c;
        while (mec < 255) begin
            c = (mexp + 1) % MOD;
            step(1, c, (c == TC_AT), 0, 0);
            feed_ok(2);
        end
        c = (mexp + 1) % MOD;
        step(1, c, (c == TC_AT), 0, 0);
        settle();
        vectors++;
        if (err_count !== 8'd255 || err_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate got ec=%0d ep=%b want 255 1",
                err_count, err_pulse);
        end
        feed_ok(2);
        c = (mexp + 1) % MOD;
        step(1, c, (c == TC_AT), 1, 0);
        settle();
        vectors++;
        if (err_count !== 8'd1 || err_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_vs_err got ec=%0d es=%b want 1 1",
                err_count, err_sticky);
        end
        step(0, 0, 0, 1, 0);
        settle();
        vectors++;
        if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL clr got ec=%0d es=%b want 0 0",
                err_count, err_sticky);
        end
        feed_ok(2);
    endtask

    task automatic test_hold();
        logic [CNT_W-1:0] ex0;
        logic [ERR_W-1:0] wc0;
        settle();
        ex0 = exp_count;
        wc0 = wrap_count;
        repeat (5) step(0, $urandom_range(0, 3), 1'($urandom), 0, 0);
        settle();
        vectors++;
        if (locked !== 1'b1 || exp_count !== ex0 || wrap_count !== wc0 ||
            err_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL hold got lk=%b ex=%0d wc=%0d ep=%b wp=%b want 1 %0d %0d 0 0",
                locked, exp_count, wrap_count, err_pulse, wrap_pulse, ex0, wc0);
        end
    endtask

    task automatic test_reset_locked();
        step(1, mexp, (mexp == TC_AT), 1, 1);
        settle();
        vectors++;
        if ({locked, exp_count, err_pulse, err_sticky, err_count,
             wrap_count, wrap_pulse} !== '0) begin
            miscompares++;
            $display("FAIL reset_locked got lk=%b ex=%0d wc=%0d want all 0",
                locked, exp_count, wrap_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_skip();
        test_tc();
        test_range();
        test_saturate();
        test_hold();
        test_reset_locked();
        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule
